// File: rtl/afifo_rdctl.sv
// afifo_rdctl: read-side controller of a dual-clock FIFO (binary count, gray crossing).
// Latency: a new word seen on i_wcnt_sync gives o_rden the same cycle and o_out_valid the next.
// Backpressure: while o_out_valid=1 and i_out_ready=0, no RAM read is issued and o_out_data holds.
//
// Everything runs in the read clock domain. The write count arrives already
// synchronized (it may lag), so the controller can only under-read, never over-read.
// The RAM has a registered output that holds while o_rden=0. That lets the
// stream data be wired straight from i_rdata with no extra output register.
//
// Ports:
//   i_clk, i_rst     read clock, synchronous active-high reset
//   i_wcnt_sync      binary write count (AWIDTH+1 bits) synchronized into i_clk
//   i_flush          drop every unread word, including the one presented
//   o_raddr, o_rden  RAM read port address / enable
//   i_rdata          RAM read data (valid the cycle after o_rden)
//   o_rcnt           binary read count, crosses back to the write domain
//   o_out_*          first-word-fall-through valid/ready stream
//   o_level          registered count of unread words still in RAM (held word excluded)
//   o_empty          nothing presented and nothing available
//   o_err            sticky protocol error; live only when AFIFO_RDCTL_CHECK_EN is defined
//
// Build option: define AFIFO_RDCTL_CHECK_EN to build the overflow / count-decrease
// checker. Without it, o_err is tied low and no check logic exists.

module afifo_rdctl #(
   parameter int AWIDTH = 4,
   parameter int DWIDTH = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [AWIDTH:0]   i_wcnt_sync,
   input  logic              i_flush,
   output logic [AWIDTH-1:0] o_raddr,
   output logic              o_rden,
   input  logic [DWIDTH-1:0] i_rdata,
   output logic [AWIDTH:0]   o_rcnt,
   output logic [DWIDTH-1:0] o_out_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [AWIDTH:0]   o_level,
   output logic              o_empty,
   output logic              o_err
);

   localparam logic [AWIDTH:0] C_ONE = {{AWIDTH{1'b0}}, 1'b1};

   typedef enum logic {
      S_EMPTY = 1'b0,   // no word presented on the stream
      S_VALID = 1'b1    // a fetched word sits on i_rdata / o_out_data
   } state_t;

   state_t            r_state;
   logic [AWIDTH:0]   r_rcnt;
   logic [AWIDTH:0]   r_level;
   logic              r_out_valid;

   logic              w_avail;
   logic              w_rden;
   logic [AWIDTH:0]   w_diff;

   // The full-width compare includes the lap bit. Equal low bits with a
   // different MSB therefore means a full RAM, not an empty one.
   assign w_avail = (i_wcnt_sync != r_rcnt);

   // Fetch when there is a word and the output slot is free or is being freed
   // this cycle. A flush suppresses the fetch, because the read pointer is
   // being moved.
   assign w_rden  = !i_rst && !i_flush && w_avail &&
                    ((r_state == S_EMPTY) || i_out_ready);

   assign w_diff  = i_wcnt_sync - r_rcnt;

   // Control FSM with registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_EMPTY;
         r_rcnt      <= '0;
         r_level     <= '0;
         r_out_valid <= 1'b0;
      end else if (i_flush) begin
         // Jumping the read count to the write count discards everything
         // unread. The level is therefore zero by construction.
         r_rcnt      <= i_wcnt_sync;
         r_state     <= S_EMPTY;
         r_out_valid <= 1'b0;
         r_level     <= '0;
      end else begin
         r_level <= w_diff;
         if (w_rden) begin
            // The word counts as read once it is fetched. The handshake
            // only moves the presented slot forward.
            r_rcnt      <= r_rcnt + C_ONE;
            r_state     <= S_VALID;
            r_out_valid <= 1'b1;
         end else if ((r_state == S_VALID) && i_out_ready && !w_avail) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
         end
      end
   end

   assign o_rden      = w_rden;
   assign o_raddr     = r_rcnt[AWIDTH-1:0];
   assign o_rcnt      = r_rcnt;
   assign o_level     = r_level;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = i_rdata;
   assign o_empty     = i_rst || ((r_state == S_EMPTY) && !w_avail);

`ifdef AFIFO_RDCTL_CHECK_EN
   localparam logic [AWIDTH:0] C_DEPTH = {1'b1, {AWIDTH{1'b0}}};

   logic [AWIDTH:0] r_wcnt_prev;
   logic            r_err;
   logic [AWIDTH:0] w_wdelta;

   // A legal write count only moves forward, and by at most DEPTH per sample.
   // A modular step larger than DEPTH means it went backwards or was corrupted.
   assign w_wdelta = i_wcnt_sync - r_wcnt_prev;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wcnt_prev <= i_wcnt_sync;
         r_err       <= 1'b0;
      end else begin
         r_wcnt_prev <= i_wcnt_sync;
         if ((r_level > C_DEPTH) || (w_wdelta > C_DEPTH))
            r_err <= 1'b1;
      end
   end

   assign o_err = r_err;
`else
   assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_afifo_rdctl.sv
// Directed bench for afifo_rdctl with a registered-output RAM model holding 0xA0+addr.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.

module tb_afifo_rdctl;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW:0]   wcnt;
   logic          flush;
   logic [AW-1:0] raddr;
   logic          rden;
   logic [DW-1:0] rdata;
   logic [AW:0]   rcnt;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic [AW:0]   level;
   logic          empty;
   logic          err;

   logic [DW-1:0] mem [0:15];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // RAM model: the output register updates only on a read
   always @(posedge clk) if (rden) rdata <= mem[raddr];

   afifo_rdctl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_wcnt_sync (wcnt),
      .i_flush     (flush),
      .o_raddr     (raddr),
      .o_rden      (rden),
      .i_rdata     (rdata),
      .o_rcnt      (rcnt),
      .o_out_data  (out_data),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_level     (level),
      .o_empty     (empty),
      .o_err       (err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; wcnt = '0; flush = 1'b0; out_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; wcnt = 5'd5; flush = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (rden !== 1'b0)      begin n_fail++; $display("FAIL reset_rden: got %b want 0", rden); end
         n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
         n_checks++; if (rcnt !== 5'd0)      begin n_fail++; $display("FAIL reset_rcnt: got %0d want 0", rcnt); end
         n_checks++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
         n_checks++; if (level !== 5'd0)     begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
      end
      rst = 1'b0;
      #1;
      n_checks++; if (rden !== 1'b1)  begin n_fail++; $display("FAIL release_rden: got %b want 1", rden); end
      n_checks++; if (raddr !== 4'd0) begin n_fail++; $display("FAIL release_raddr: got %0d want 0", raddr); end
      // re-enter reset with an empty FIFO before the edge so nothing is consumed
      rst = 1'b1; wcnt = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single;
      #1;
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_idle_empty: got %b want 1", empty); end
      n_checks++; if (rden !== 1'b0)  begin n_fail++; $display("FAIL single_idle_rden: got %b want 0", rden); end
      wcnt = 5'd1;
      #1;
      n_checks++; if (rden !== 1'b1)  begin n_fail++; $display("FAIL single_rden: got %b want 1", rden); end
      n_checks++; if (raddr !== 4'd0) begin n_fail++; $display("FAIL single_raddr: got %0d want 0", raddr); end
      tick();
      n_checks++; if (rden !== 1'b0)      begin n_fail++; $display("FAIL single_rden_once: got %b want 0", rden); end
      n_checks++; if (rcnt !== 5'd1)      begin n_fail++; $display("FAIL single_rcnt: got %0d want 1", rcnt); end
      n_checks++; if (empty !== 1'b0)     begin n_fail++; $display("FAIL single_empty: got %b want 0", empty); end
      for (int i = 0; i < 10; i++) begin
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_hold_valid: cycle %0d got %b want 1", i, out_valid); end
         n_checks++; if (out_data !== 8'hA0) begin n_fail++; $display("FAIL single_hold_data: cycle %0d got %h want a0", i, out_data); end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain_valid: got %b want 0", out_valid); end
      n_checks++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL single_drain_empty: got %b want 1", empty); end
   endtask

   task automatic test_burst;
      do_reset();
      wcnt = 5'd8; out_ready = 1'b1;
      #1;
      for (int k = 0; k < 10; k++) begin
         if (k < 8) begin
            n_checks++; if (rden !== 1'b1)     begin n_fail++; $display("FAIL burst_rden: k=%0d got %b want 1", k, rden); end
            n_checks++; if (raddr !== 4'(k))   begin n_fail++; $display("FAIL burst_raddr: k=%0d got %0d want %0d", k, raddr, k); end
         end else begin
            n_checks++; if (rden !== 1'b0)     begin n_fail++; $display("FAIL burst_rden_end: k=%0d got %b want 0", k, rden); end
         end
         if (k == 0 || k == 9) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL burst_valid_low: k=%0d got %b want 0", k, out_valid); end
         end else begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL burst_valid: k=%0d got %b want 1", k, out_valid); end
            n_checks++; if (out_data !== 8'hA0 + 8'(k - 1)) begin n_fail++; $display("FAIL burst_data: k=%0d got %h want %h", k, out_data, 8'hA0 + 8'(k - 1)); end
         end
         tick();
      end
      n_checks++; if (rcnt !== 5'd8) begin n_fail++; $display("FAIL burst_rcnt: got %0d want 8", rcnt); end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      int got;
      int rd_seen;
      got = 0; rd_seen = 0;
      do_reset();
      wcnt = 5'd6;
      for (int c = 0; c < 60 && got < 6; c++) begin
         out_ready = ((c % 4) == 0) || ((c % 4) == 3);
         #1;
         if (rden) begin
            n_checks++; if (raddr !== 4'(rd_seen)) begin n_fail++; $display("FAIL bp_raddr: got %0d want %0d", raddr, rd_seen); end
            rd_seen++;
         end
         if (out_valid) begin
            // the presented word must be the next undelivered one, stalled or not
            n_checks++; if (out_data !== 8'hA0 + 8'(got)) begin n_fail++; $display("FAIL bp_data: c=%0d got %h want %h", c, out_data, 8'hA0 + 8'(got)); end
            if (out_ready) got++;
            else begin
               n_checks++; if (rden !== 1'b0) begin n_fail++; $display("FAIL bp_stall_rden: c=%0d got %b want 0", c, rden); end
            end
         end
         tick();
      end
      out_ready = 1'b0;
      n_checks++; if (got != 6)     begin n_fail++; $display("FAIL bp_count: delivered %0d want 6 within budget", got); end
      n_checks++; if (rd_seen != 6) begin n_fail++; $display("FAIL bp_reads: got %0d want 6", rd_seen); end
      n_checks++; if (rcnt !== 5'd6) begin n_fail++; $display("FAIL bp_rcnt: got %0d want 6", rcnt); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_final_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_wrap;
      logic [3:0] exp_addr [5];
      exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
      do_reset();
      flush = 1'b1; wcnt = 5'd30; out_ready = 1'b1;
      #1;
      n_checks++; if (rden !== 1'b0) begin n_fail++; $display("FAIL wrap_preload_rden: got %b want 0", rden); end
      tick();
      flush = 1'b0;
      n_checks++; if (rcnt !== 5'd30) begin n_fail++; $display("FAIL wrap_preload_rcnt: got %0d want 30", rcnt); end
      n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL wrap_preload_level: got %0d want 0", level); end
      wcnt = 5'd3;
      #1;
      for (int k = 0; k < 7; k++) begin
         if (k < 5) begin
            n_checks++; if (rden !== 1'b1) begin n_fail++; $display("FAIL wrap_rden: k=%0d got %b want 1", k, rden); end
            n_checks++; if (raddr !== exp_addr[k]) begin n_fail++; $display("FAIL wrap_raddr: k=%0d got %0d want %0d", k, raddr, exp_addr[k]); end
         end else begin
            n_checks++; if (rden !== 1'b0) begin n_fail++; $display("FAIL wrap_rden_end: k=%0d got %b want 0", k, rden); end
         end
         if (k >= 1 && k <= 5) begin
            n_checks++; if (out_data !== {4'hA, exp_addr[k - 1]}) begin n_fail++; $display("FAIL wrap_data: k=%0d got %h want %h", k, out_data, {4'hA, exp_addr[k - 1]}); end
         end
         if (k >= 1) begin
            n_checks++; if (level !== 5'(6 - k)) begin n_fail++; $display("FAIL wrap_level: k=%0d got %0d want %0d", k, level, 6 - k); end
         end
         tick();
      end
      out_ready = 1'b0;
      n_checks++; if (rcnt !== 5'd3)  begin n_fail++; $display("FAIL wrap_rcnt: got %0d want 3", rcnt); end
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty: got %b want 1", empty); end
   endtask

   task automatic test_flush;
      do_reset();
      wcnt = 5'd4; out_ready = 1'b1;
      repeat (4) tick();
      n_checks++; if (rcnt !== 5'd4)      begin n_fail++; $display("FAIL flush_pre_rcnt: got %0d want 4", rcnt); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
      flush = 1'b1; wcnt = 5'd9;
      #1;
      n_checks++; if (rden !== 1'b0) begin n_fail++; $display("FAIL flush_rden: got %b want 0", rden); end
      tick();
      flush = 1'b0;
      #1;
      n_checks++; if (rcnt !== 5'd9)      begin n_fail++; $display("FAIL flush_rcnt: got %0d want 9", rcnt); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
      n_checks++; if (level !== 5'd0)     begin n_fail++; $display("FAIL flush_level: got %0d want 0", level); end
      n_checks++; if (rden !== 1'b0)      begin n_fail++; $display("FAIL flush_after_rden: got %b want 0", rden); end
      n_checks++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL flush_empty: got %b want 1", empty); end
      out_ready = 1'b0;
   endtask

   task automatic test_checker;
      logic exp_err;
`ifdef AFIFO_RDCTL_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      do_reset();
      #1;
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL chk_reset_err: got %b want 0", err); end
      wcnt = rcnt + 5'd17;
      repeat (3) tick();
      n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL chk_err_set: got %b want %b", err, exp_err); end
      repeat (20) tick();
      n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL chk_err_sticky: got %b want %b", err, exp_err); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
      rst = 1'b1; flush = 1'b0; wcnt = '0; out_ready = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_backpressure();
      test_wrap();
      test_flush();
      test_checker();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/afifo_rdctl.md
Name: afifo_rdctl

Overview:
- Read-side controller for a dual-clock FIFO built on the binary-counter gray crossing.
- Runs entirely in the read clock domain and consumes the write count after it has been synchronized into this domain.
- Sequences reads of a dual-port RAM (registered output) and presents a first-word-fall-through valid/ready stream.
- Exports its own binary read count for crossing back to the write domain.

Parameters:
- AWIDTH, 4, RAM address width; DEPTH = 2**AWIDTH words; counters are AWIDTH+1 bits.
- DWIDTH, 8, data word width.

Ports:
- clk  input  1  read-domain clock.
- rst  input  1  synchronous, active-high reset.
- wcnt_sync  input  AWIDTH+1  binary write count, already synchronized into clk domain; may lag the true value.
- flush  input  1  discard all unread words, including the held output word.
- raddr  output  AWIDTH  RAM read address.
- rden  output  1  RAM read enable; RAM output updates the cycle after rden=1 and holds while rden=0.
- rdata  input  DWIDTH  RAM read data.
- rcnt  output  AWIDTH+1  binary read count; feeds the crossing toward the write domain.
- out_data  output  DWIDTH  stream data, wired directly to rdata.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready.
- level  output  AWIDTH+1  registered count of unread words in RAM; excludes the held output word.
- empty  output  1  no word held and none available.
- err  output  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset, synchronous, rst=1 at a clk edge: rcnt=0, state=S_EMPTY, out_valid=0, level=0, err=0. rden=0 and empty=1 while rst is high.
- avail = (wcnt_sync != rcnt), full-width compare; the MSB distinguishes wrap laps.
- States:
  - S_EMPTY: out_valid=0.
  - S_VALID: out_valid=1.
- rden (combinational) = !rst & !flush & avail & (state==S_EMPTY | out_ready).
- raddr = rcnt[AWIDTH-1:0] (combinational).
- Transitions, priority top-down:
  - flush=1: rcnt<=wcnt_sync; state<=S_EMPTY; no rden. Flush wins over a simultaneous out_ready or avail.
  - rden=1: rcnt<=rcnt+1 (mod 2**(AWIDTH+1)); state<=S_VALID.
  - state==S_VALID & out_ready & !avail: state<=S_EMPTY.
  - Otherwise: hold.
- Latency:
  - First word: wcnt_sync change at cycle t gives rden at t and out_valid at t+1.
  - Throughput: one word per clk while out_ready=1 and avail.
- Backpressure: while out_valid=1 and out_ready=0, rden stays 0 and out_data stays stable.
- level <= wcnt_sync - rcnt, mod 2**(AWIDTH+1), using current-cycle values (one-cycle lag).
- empty = (state==S_EMPTY) & !avail, combinational.
- Wrap-around: rcnt rolls from 2**(AWIDTH+1)-1 to 0 with no gap in reads. raddr rolls from DEPTH-1 to 0.
- A stale wcnt_sync only delays reads; the controller never reads past it.
- Handshake: a transfer occurs when out_valid & out_ready. The word is already counted in rcnt when it is fetched.

Optional Feature:
- Macro: AFIFO_RDCTL_CHECK_EN.
- Defined:
  - err sets and stays set until rst when a registered difference (wcnt_sync - rcnt) exceeds DEPTH, i.e. overflow or a corrupted crossing.
  - err also sets when wcnt_sync decreases: (wcnt_sync - wcnt_sync_prev) mod 2**(AWIDTH+1) > DEPTH.
  - Flow control is unaffected.
- Undefined: err tied to 0; no check logic is synthesized.

Test Plan:
- Reset: hold rst=1 for 3 clk with wcnt_sync=5 -> rden=0, out_valid=0, rcnt=0, empty=1, level=0. Then release rst -> rden=1 in the same cycle with raddr=0.
- Single word: wcnt_sync 0->1, out_ready=0 -> rden=1 for one cycle, out_valid=1 from the next cycle and held for 10 cycles, rcnt=1, empty=0. Then out_ready=1 for one cycle -> out_valid=0, empty=1.
- Burst: RAM holds 0xA0..0xA7, wcnt_sync=8, out_ready=1 -> 8 consecutive rden with raddr 0..7, out_data 0xA0..0xA7 on 8 consecutive valid cycles, rcnt=8.
- Backpressure: burst with out_ready toggling 1,0,0,1 -> each word delivered exactly once, in order, with out_data stable while stalled.
- Wrap (AWIDTH=4): preload rcnt=wcnt_sync=30, then set wcnt_sync=3 (5 words) -> raddr 14,15,0,1,2, rcnt ends at 3, level goes 5→0.
- Flush / checker:
  - flush=1 with out_valid=1, wcnt_sync=9, rcnt=4 -> next cycle rcnt=9, out_valid=0, no rden, level=0.
  - With AFIFO_RDCTL_CHECK_EN: set wcnt_sync = rcnt+17 -> err=1, still set after 20 cycles.
  - Without AFIFO_RDCTL_CHECK_EN: same stimulus -> err=0.
